// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states and the HALT opcode.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEM,
    S_LOAD,
    S_START,
    S_GUARD,
    S_EXEC
  } fetch_state_t;

  localparam logic [2:0] OPC_HALT = 3'b111;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: synchronous reset to START_ADDR, increments on inc, wraps modulo 2^ADDR_W.
module fetch_pc #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_W'(START_ADDR);
    end else if (inc) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch/issue sequencer for the cpu: reads an instruction at pc, loads and starts the cpu,
// waits for completion, then advances pc. Stops on HALT, on run low, or on watchdog expiry.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned WDOG_MAX   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  input  logic              cpu_w,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              timeout
);

  localparam int unsigned WdogW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(WDOG_MAX);

  fetch_state_t      state_q;
  logic              mem_rd_q;
  logic              cpu_load_q;
  logic              cpu_s_q;
  logic [DATA_W-1:0] cpu_in_q;
  logic              halted_q;
  logic              timeout_q;
  logic [WdogW-1:0]  wdog_q;
  logic              pc_inc;

  // pc advances on the same edge that sees the cpu report completion.
  assign pc_inc = (state_q == S_EXEC) && cpu_w;

  fetch_pc #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_fetch_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_rd_q   <= 1'b0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      cpu_in_q   <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      wdog_q     <= '0;
    end else begin
      mem_rd_q   <= 1'b0;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run && cpu_w && !halted_q && !timeout_q) begin
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_MEM;
        S_MEM: begin
          cpu_in_q   <= mem_rdata;
          cpu_load_q <= 1'b1;
          state_q    <= S_LOAD;
        end
        S_LOAD: begin
          if (cpu_in_q[15:13] == OPC_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cpu_s_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: state_q <= S_GUARD;
        // cpu_w may still read high here from before the start pulse took effect.
        S_GUARD: begin
          wdog_q  <= '0;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (cpu_w) begin
            wdog_q <= '0;
            if (run) begin
              state_q  <= S_FETCH;
              mem_rd_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (wdog_q == WdogMax) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr = pc;
  assign mem_rd   = mem_rd_q;
  assign cpu_load = cpu_load_q;
  assign cpu_s    = cpu_s_q;
  assign cpu_in   = cpu_in_q;
  assign halted   = halted_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for a single instruction plus multi-cycle sequences.
module tb_instr_fetch;

  localparam int unsigned WDOG = 255;

  logic        clk;
  logic        reset;
  logic        run;
  logic        cpu_w;
  logic        mem_rd, cpu_load, cpu_s, halted, timeout;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_rdata, cpu_in;
  logic        mem_rd2, cpu_load2, cpu_s2, halted2, timeout2;
  logic [7:0]  mem_addr2, pc2;
  logic [15:0] mem_rdata2, cpu_in2;

  logic [15:0] mem  [256];
  logic [15:0] mem2 [256];

  int checks   = 0;
  int failures = 0;
  int n_rd     = 0;
  int n_s      = 0;
  int n_both   = 0;
  int exec_len = 2;
  int busy     = 0;
  bit hang     = 1'b0;

  instr_fetch #(
    .ADDR_W (8), .DATA_W (16), .START_ADDR (0), .WDOG_MAX (WDOG)
  ) dut (
    .clk (clk), .reset (reset), .run (run), .mem_rd (mem_rd), .mem_addr (mem_addr),
    .mem_rdata (mem_rdata), .cpu_in (cpu_in), .cpu_load (cpu_load), .cpu_s (cpu_s),
    .cpu_w (cpu_w), .pc (pc), .halted (halted), .timeout (timeout)
  );

  instr_fetch #(
    .ADDR_W (8), .DATA_W (16), .START_ADDR (255), .WDOG_MAX (WDOG)
  ) dut2 (
    .clk (clk), .reset (reset), .run (run), .mem_rd (mem_rd2), .mem_addr (mem_addr2),
    .mem_rdata (mem_rdata2), .cpu_in (cpu_in2), .cpu_load (cpu_load2), .cpu_s (cpu_s2),
    .cpu_w (cpu_w), .pc (pc2), .halted (halted2), .timeout (timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= mem[mem_addr];
    if (mem_rd2) mem_rdata2 <= mem2[mem_addr2];
  end

  // cpu stand-in: leaves wait on the edge that samples s, returns after exec_len cycles unless hung.
  always @(posedge clk) begin
    if (reset) begin
      cpu_w <= 1'b1;
      busy  <= 0;
    end else if (cpu_s) begin
      cpu_w <= 1'b0;
      busy  <= exec_len;
    end else if (!cpu_w && !hang) begin
      if (busy <= 1) cpu_w <= 1'b1;
      if (busy > 0) busy <= busy - 1;
    end
  end

  always @(negedge clk) begin
    if (mem_rd) n_rd <= n_rd + 1;
    if (cpu_s) n_s <= n_s + 1;
    if ((cpu_load && cpu_s) || (cpu_load2 && cpu_s2)) n_both <= n_both + 1;
  end

  typedef struct {
    logic        run;
    logic        mem_rd;
    logic        cpu_load;
    logic        cpu_s;
    logic [7:0]  pc;
    logic [15:0] cpu_in;
  } vec_t;

  vec_t vec [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return cpu_s;
      1:       return halted;
      2:       return halted2;
      default: return mem_rd;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int max);
    bit hit;
    hit = cond(sel);
    for (int n = 0; n < max && !hit; n++) begin
      tick();
      hit = cond(sel);
    end
    chk(name, {63'd0, hit}, 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_strobes", {61'd0, mem_rd, cpu_load, cpu_s}, 64'd0);
    chk("rst_pc", {48'd0, mem_addr, pc}, 64'd0);
    chk("rst_flags", {62'd0, halted, timeout}, 64'd0);
    chk("rst_cpu_in", {48'd0, cpu_in}, 64'd0);
    chk("rst_pc2", {56'd0, pc2}, 64'hFF);
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0000;
      mem2[i] = 16'h0000;
    end
  endtask

  int r0;
  int s0;

  initial begin
    reset = 1'b1;
    run   = 1'b0;

    // c1 FETCH, c2 MEM, c3 LOAD, c4 START, c5 GUARD, c6-c7 EXEC, c8 next FETCH at pc 1.
    vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000};
    vec[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
    vec[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'hD105};
    vec[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'hD105};
    vec[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hD105};
    vec[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hD105};
    vec[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'hD105};
    vec[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 16'hD105};

    // Single MOV, cycle by cycle.
    clear_mem();
    mem[0]   = 16'hD105;
    mem[1]   = 16'hE000;
    run      = 1'b1;
    exec_len = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run = vec[i].run;
      tick();
      chk($sformatf("t1_c%0d", i + 1),
          {29'd0, mem_rd, cpu_load, cpu_s, mem_addr, pc, cpu_in},
          {29'd0, vec[i].mem_rd, vec[i].cpu_load, vec[i].cpu_s, vec[i].pc, vec[i].pc,
           vec[i].cpu_in});
    end
    wait_for("t1_halt_wait", 1, 20);
    chk("t1_halt_pc", {56'd0, pc}, 64'd1);

    // MOV, ADD, HALT.
    clear_mem();
    mem[0] = 16'hD105;
    mem[1] = 16'h6123;
    mem[2] = 16'hE000;
    mem[3] = 16'hD105;
    do_reset();
    s0 = n_s;
    r0 = n_rd;
    wait_for("t2_halt_wait", 1, 100);
    chk("t2_pc", {56'd0, pc}, 64'd2);
    chk("t2_starts", 64'(n_s - s0), 64'd2);
    chk("t2_reads", 64'(n_rd - r0), 64'd3);
    repeat (10) tick();
    chk("t2_idle_reads", 64'(n_rd - r0), 64'd3);
    chk("t2_idle_state", {47'd0, halted, pc, cpu_in}, {47'd1, 8'd2, 16'hE000});

    // PC wrap from FF to 00 on the START_ADDR=FF instance.
    clear_mem();
    mem[0]     = 16'hD105;
    mem[1]     = 16'hE000;
    mem2[8'hFF] = 16'hD105;
    mem2[8'h00] = 16'hE000;
    do_reset();
    chk("t3_addr_rst", {56'd0, mem_addr2}, 64'hFF);
    wait_for("t3_halt_wait", 2, 100);
    chk("t3_wrap", {46'd0, halted2, timeout2, pc2, cpu_in2}, {46'd2, 8'h00, 16'hE000});

    // Hung cpu: watchdog fires after WDOG+1 cycles in S_EXEC.
    clear_mem();
    mem[0] = 16'hD105;
    hang   = 1'b1;
    do_reset();
    wait_for("t4_start_wait", 0, 20);
    repeat (WDOG + 2) tick();
    chk("t4_before_timeout", {63'd0, timeout}, 64'd0);
    tick();
    chk("t4_timeout", {63'd0, timeout}, 64'd1);
    r0   = n_rd;
    hang = 1'b0;
    repeat (20) tick();
    chk("t4_no_refetch", 64'(n_rd - r0), 64'd0);
    chk("t4_idle", {54'd0, cpu_w, timeout, pc}, {54'd3, 8'd0});

    // run dropped mid-instruction, then re-raised.
    clear_mem();
    mem[0]   = 16'hD105;
    mem[1]   = 16'h6123;
    mem[2]   = 16'hE000;
    exec_len = 4;
    do_reset();
    wait_for("t5_start_wait", 0, 20);
    tick();
    tick();
    run = 1'b0;
    r0  = n_rd;
    repeat (10) tick();
    chk("t5_stop_pc", {55'd0, halted, pc}, 64'd1);
    chk("t5_stop_reads", 64'(n_rd - r0), 64'd0);
    run = 1'b1;
    wait_for("t5_resume_wait", 3, 5);
    chk("t5_resume_addr", {56'd0, mem_addr}, 64'd1);
    wait_for("t5_halt_wait", 1, 100);
    chk("t5_halt_pc", {56'd0, pc}, 64'd2);

    // Reset in S_START and in S_EXEC.
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 16'hD105;
    exec_len = 2;
    do_reset();
    wait_for("t6_start0_wait", 0, 20);
    tick();
    wait_for("t6_start1_wait", 0, 20);
    chk("t6_pre_start_pc", {56'd0, pc}, 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_start_rst", {37'd0, mem_rd, cpu_load, cpu_s, halted, timeout, pc, cpu_in}, 64'd0);
    reset = 1'b0;
    wait_for("t6_start2_wait", 0, 20);
    tick();
    wait_for("t6_start3_wait", 0, 20);
    tick();
    tick();
    chk("t6_pre_exec_pc", {56'd0, pc}, 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_exec_rst", {37'd0, mem_rd, cpu_load, cpu_s, halted, timeout, pc, cpu_in}, 64'd0);
    reset = 1'b0;
    tick();

    chk("load_s_overlap", 64'(n_both), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
